// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronises and glitch-filters the encoder pins, then
// turns each accepted Gray-code move into a one-cycle step (countEN/inc) or error strobe.
module quad_step_decoder #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  input  logic       a_in,
  input  logic       b_in,
  output logic       countEN,
  output logic       inc,
  output logic       err,
  output logic [7:0] pos,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [1:0] ARM_EDGES = 2'd2;

  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  phase_t     filt_q, filt_d;
  phase_t     state_q, state_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [1:0] arm_q, arm_d;
  logic       count_en_q, count_en_d;
  logic       inc_q, inc_d;
  logic       err_q, err_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  function automatic phase_t step_fwd(input phase_t ph);
    case (ph)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  function automatic phase_t step_rev(input phase_t ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    s1_d       = {a_in, b_in};
    s2_d       = s1_q;
    filt_d     = filt_q;
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    arm_d      = arm_q;
    count_en_d = 1'b0;
    err_d      = 1'b0;
    inc_d      = inc_q;
    pos_d      = pos_q;
    err_cnt_d  = err_cnt_q;

    if (arm_q != ARM_EDGES) begin
      // Arming seeds filt/state with the value s2 takes on this edge, so a pair
      // that was stable through clear is adopted silently instead of decoded.
      arm_d   = arm_q + 2'd1;
      filt_d  = phase_t'(s2_d);
      state_d = phase_t'(s2_d);
      fcnt_d  = '0;
    end else begin
      if (s2_q == filt_q) begin
        fcnt_d = '0;
      end else if (fcnt_q >= FILT_LAST) begin
        filt_d = phase_t'(s2_q);
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end

      if (state_q != filt_q) begin
        state_d = filt_q;
        if (enable) begin
          if (filt_q == step_fwd(state_q)) begin
            count_en_d = 1'b1;
            inc_d      = 1'b1;
            pos_d      = pos_q + 8'd1;
          end else if (filt_q == step_rev(state_q)) begin
            count_en_d = 1'b1;
            inc_d      = 1'b0;
            pos_d      = pos_q - 8'd1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= PH_00;
      state_q    <= PH_00;
      fcnt_q     <= '0;
      arm_q      <= '0;
      count_en_q <= 1'b0;
      inc_q      <= 1'b0;
      err_q      <= 1'b0;
      pos_q      <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      arm_q      <= arm_d;
      count_en_q <= count_en_d;
      inc_q      <= inc_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign countEN = count_en_q;
  assign inc     = inc_q;
  assign err     = err_q;
  assign pos     = pos_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (FILTER_LEN=3): arming, stepping, wrap,
// glitch rejection, illegal transitions, enable gating and mid-step clear.
`timescale 1ns/1ps
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       clear, enable, a_in, b_in;
  logic       countEN, inc, err;
  logic [7:0] pos, err_cnt;

  int checks = 0;
  int errors = 0;
  int n_pulse, n_err, first_pulse, t, both_hi;

  quad_step_decoder #(.FILTER_LEN(3)) dut (
    .clk     (clk),
    .clear   (clear),
    .enable  (enable),
    .a_in    (a_in),
    .b_in    (b_in),
    .countEN (countEN),
    .inc     (inc),
    .err     (err),
    .pos     (pos),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (countEN) begin
      n_pulse++;
      if (first_pulse < 0) first_pulse = t;
    end
    if (err) n_err++;
    if (countEN && err) both_hi++;
    t++;
  endtask

  task automatic clr_stats();
    n_pulse     = 0;
    n_err       = 0;
    first_pulse = -1;
    t           = 0;
  endtask

  task automatic drive(input logic [1:0] ab, input int cycles);
    a_in = ab[1];
    b_in = ab[0];
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic do_clear(input logic [1:0] ab);
    a_in  = ab[1];
    b_in  = ab[0];
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    drive(ab, 10);
  endtask

  logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    both_hi = 0;
    clr_stats();
    clear  = 1'b1;
    enable = 1'b1;
    a_in   = 1'b1;
    b_in   = 1'b1;
    tick();
    tick();
    check("rst_countEN", countEN, 0);
    check("rst_inc", inc, 0);
    check("rst_err", err, 0);
    check("rst_pos", pos, 0);
    check("rst_err_cnt", err_cnt, 0);

    // Arming at 11: no error, and 11->10 is then a forward step.
    clear = 1'b0;
    clr_stats();
    drive(2'b11, 10);
    check("arm_no_err", n_err, 0);
    check("arm_no_step", n_pulse, 0);
    clr_stats();
    drive(2'b10, 8);
    check("arm_step_from_11", n_pulse, 1);
    check("arm_inc", inc, 1);
    check("arm_pos", pos, 1);

    // Forward cycle, 5-edge latency each step.
    do_clear(2'b00);
    check("fwd_start_pos", pos, 0);
    for (int i = 0; i < 4; i++) begin
      clr_stats();
      drive(fwd_seq[i], 8);
      check($sformatf("fwd_pulses%0d", i), n_pulse, 1);
      check($sformatf("fwd_latency%0d", i), first_pulse, 5);
      check($sformatf("fwd_inc%0d", i), inc, 1);
      check($sformatf("fwd_err%0d", i), n_err, 0);
    end
    check("fwd_pos", pos, 4);

    // Reverse with wrap below zero, then forward wrap back through 255.
    do_clear(2'b00);
    clr_stats();
    drive(2'b10, 8);
    check("rev_pos_wrap", pos, 255);
    check("rev_inc0", inc, 0);
    drive(2'b11, 8);
    check("rev_pulses", n_pulse, 2);
    check("rev_pos", pos, 254);
    check("rev_inc1", inc, 0);
    drive(2'b10, 8);
    check("fwd_pos_255", pos, 255);
    drive(2'b00, 8);
    check("fwd_pos_wrap", pos, 0);
    check("fwd_wrap_inc", inc, 1);

    // Two-cycle glitch is ignored; three-cycle pulse is accepted both ways.
    clr_stats();
    drive(2'b10, 2);
    drive(2'b00, 10);
    check("glitch2_pulses", n_pulse, 0);
    check("glitch2_err", n_err, 0);
    check("glitch2_pos", pos, 0);
    clr_stats();
    drive(2'b10, 3);
    drive(2'b00, 4);
    check("glitch3_pulses", n_pulse, 1);
    check("glitch3_latency", first_pulse, 5);
    check("glitch3_inc", inc, 0);
    check("glitch3_pos", pos, 255);
    drive(2'b00, 8);
    check("glitch3_back_pulses", n_pulse, 2);
    check("glitch3_back_inc", inc, 1);
    check("glitch3_back_pos", pos, 0);

    // Illegal double-bit moves and err_cnt saturation.
    clr_stats();
    drive(2'b11, 8);
    check("ill_err", n_err, 1);
    check("ill_no_step", n_pulse, 0);
    check("ill_err_cnt", err_cnt, 1);
    check("ill_pos", pos, 0);
    clr_stats();
    for (int i = 1; i < 260; i++) drive((i % 2 == 1) ? 2'b00 : 2'b11, 8);
    check("ill_err_pulses", n_err, 259);
    check("ill_sat", err_cnt, 255);
    check("ill_sat_no_step", n_pulse, 0);
    check("ill_sat_pos", pos, 0);

    // Disabled steps are tracked but not counted; no retroactive step.
    enable = 1'b0;
    clr_stats();
    drive(2'b01, 8);
    drive(2'b11, 8);
    check("dis_pulses", n_pulse, 0);
    check("dis_err", n_err, 0);
    check("dis_pos", pos, 0);
    check("dis_err_cnt", err_cnt, 255);
    enable = 1'b1;
    drive(2'b11, 10);
    check("reen_no_retro", n_pulse, 0);
    drive(2'b10, 8);
    check("reen_pulses", n_pulse, 1);
    check("reen_pos", pos, 1);
    check("reen_inc", inc, 1);

    // Clear lands on the edge filt would accept 00.
    clr_stats();
    drive(2'b00, 4);
    clear = 1'b1;
    tick();
    check("mid_clr_countEN", countEN, 0);
    check("mid_clr_inc", inc, 0);
    check("mid_clr_pos", pos, 0);
    check("mid_clr_err_cnt", err_cnt, 0);
    clear = 1'b0;
    drive(2'b00, 10);
    check("mid_clr_no_pulse", n_pulse, 0);
    check("mid_clr_no_err", n_err, 0);
    check("mid_clr_pos_after", pos, 0);

    check("never_both_high", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Decodes a 2-phase quadrature encoder (A/B) into single-cycle step commands: countEN strobe plus inc direction.
- These outputs drive the count-enable/direction interface of the team's 8-bit up/down counter directly.
- Also keeps its own wrapping 8-bit position mirror and a saturating illegal-transition counter for diagnostics.
- Sits between asynchronous encoder pins and the counter datapath.

Parameters:
- FILTER_LEN, 3, consecutive cycles the synchronised A/B pair must differ from the filtered value before it is accepted (legal 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- clear  input  1  synchronous active-high reset.
- enable  input  1  step/error generation enable.
- a_in  input  1  encoder phase A, asynchronous.
- b_in  input  1  encoder phase B, asynchronous.
- countEN  output  1  one-cycle step strobe.
- inc  output  1  direction of the most recent step: 1 = up, 0 = down.
- err  output  1  one-cycle strobe on an illegal (double-bit) transition.
- pos  output  8  position mirror.
- err_cnt  output  8  illegal-transition count.

Behaviour:
- Reset: one clock; clear is synchronous and active-high. At a rising clk edge with clear=1:
  - countEN, inc, err, pos, err_cnt <= 0.
  - Both sync flop pairs <= 0; filter counter <= 0; filtered pair filt <= 00; decoder state <= 00; arm counter <= 0.
- clear has priority over every other event, including mid-step.
- Synchroniser: two flops per input, s1 then s2, giving the pair {A,B}.
- Arming:
  - For the first 2 edges after clear deasserts, filt and state load s2 directly.
  - No countEN or err is produced while arming.
  - Arming then completes and stays done until the next clear.
- Glitch filter (armed only):
  - s2 == filt: filter counter <= 0.
  - Otherwise the counter increments each edge.
  - On the FILTER_LEN-th consecutive differing edge, filt <= s2 and the counter <= 0.
- Decoder states follow the Gray order 00 -> 01 -> 11 -> 10 -> 00, evaluated on the edge after filt changes:
  - Forward neighbour: countEN <= 1, inc <= 1, pos <= pos+1 (mod 256).
  - Reverse neighbour: countEN <= 1, inc <= 0, pos <= pos-1 (mod 256).
  - Both bits changed: err <= 1, err_cnt <= err_cnt+1 saturating at 255, no step, pos unchanged.
  - In all three cases state <= filt.
- countEN and err are high for exactly one cycle per accepted change and are never both high.
- inc holds its value between steps.
- enable=0:
  - Synchroniser, filter and state keep tracking.
  - countEN, err, pos and err_cnt do not change.
  - Re-enabling produces no retroactive step.
- Latency: with first capture into s1 at edge k and inputs then stable, countEN/err rise at edge k+FILTER_LEN+2. Example: FILTER_LEN=3 gives edge k+5.
- Glitches: a change at s2 lasting fewer than FILTER_LEN cycles is ignored, and the filter counter returns to 0.
- Wrap: pos 255 + forward step = 0; pos 0 + reverse step = 255.
- Step rate: at most one step per FILTER_LEN+1 cycles. Faster input is undefined and need not be detected.

Test Plan:
- Reset/arm: clear 1 for 2 cycles with a_in=b_in=1 -> all outputs 0, no err after arming, state=11.
- Forward: armed at 00, FILTER_LEN=3, drive 01,11,10,00 each held 8 cycles -> 4 countEN pulses, each 5 edges after input change, inc=1, pos=4.
- Reverse and wrap: from pos=0 drive 00 -> 10 -> 11 -> pos=254, inc=0, two pulses.
- Glitch: toggle a_in high for 2 cycles then back -> no countEN, no err, pos unchanged. Hold it 3 cycles -> one pulse.
- Illegal: from 00 jump to 11 (held 8 cycles) -> one err pulse, err_cnt=1, no countEN. Repeat 260 times -> err_cnt=255.
- Enable and mid-op reset:
  - enable=0 during two forward steps -> pos unchanged; the next enabled step counts normally.
  - Assert clear on the edge filt changes -> no pulse, all outputs 0.
